// File: rtl/round_robin_arbiter.sv
// Registered N-way arbiter, fixed or round-robin priority, sticky grant with optional max hold.
// Latency: request to grant 1 cycle; owner switches back-to-back with no idle cycle.
// Backpressure: none; requests are levels and the grant is held while the owner keeps requesting.
module round_robin_arbiter #(
  parameter int width       = 4,
  parameter int index_width = 2,
  parameter int mode        = 1,
  parameter int max_hold    = 0,
  parameter int hold_width  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [width-1:0]       i_request,
  output logic [width-1:0]       o_grant,
  output logic                   o_valid,
  output logic [index_width-1:0] o_index
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] GRANTED = 1'b1;

  localparam logic [hold_width-1:0] hold_lim = hold_width'(max_hold);
  localparam logic [hold_width-1:0] hold_one = hold_width'(1);
  localparam logic [width-1:0]      bit_zero = width'(1);

  logic [0:0]             state_q, state_d;
  logic [width-1:0]       grant_q, grant_d;
  logic [index_width-1:0] index_q, index_d;
  logic [index_width-1:0] ptr_q, ptr_d;
  logic [hold_width-1:0]  hold_q, hold_d;

  logic                   owner_req;
  logic                   hold_expired;
  logic [width-1:0]       cand;
  logic                   hi_found, lo_found;
  logic [index_width-1:0] hi_idx, lo_idx;
  logic                   win_vld;
  logic [index_width-1:0] win_idx;
  logic [width-1:0]       win_onehot;
  logic [index_width-1:0] win_next_ptr;

  // Owner status and the candidate vector; an expired owner is masked so others get a turn
  always_comb begin
    owner_req    = (state_q == GRANTED) && ((i_request & grant_q) != '0);
    hold_expired = (max_hold != 0) && (hold_q >= hold_lim);
    cand         = (owner_req && hold_expired) ? (i_request & ~grant_q) : i_request;
  end

  // Winner select: lowest set bit at or above the pointer, falling back to lowest overall
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = width - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_found = 1'b1;
        lo_idx   = index_width'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = index_width'(i);
        end
      end
    end
    win_vld      = lo_found;
    win_idx      = ((mode != 0) && hi_found) ? hi_idx : lo_idx;
    win_onehot   = bit_zero << win_idx;
    // Fixed priority never rotates, so its pointer is pinned at zero
    if (mode == 0) begin
      win_next_ptr = '0;
    end else if (win_idx == index_width'(width - 1)) begin
      win_next_ptr = '0;
    end else begin
      win_next_ptr = win_idx + 1'b1;
    end
  end

  // Next-state decision: hold, retain after expiry, switch, or drop to idle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (owner_req && !hold_expired) begin
      if (hold_q != '1) begin
        hold_d = hold_q + hold_one;
      end
    end else if (win_vld) begin
      // New grant, whether from idle, owner drop, or expiry with a competitor waiting
      state_d = GRANTED;
      grant_d = win_onehot;
      index_d = win_idx;
      ptr_d   = win_next_ptr;
      hold_d  = hold_one;
    end else if (owner_req) begin
      // Expired but nobody else wants the resource: owner keeps it, window restarts
      hold_d = hold_one;
    end else begin
      state_d = IDLE;
      grant_d = '0;
      index_d = '0;
      hold_d  = '0;
    end
  end

  // State registers; synchronous reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      index_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign o_grant = grant_q;
  assign o_index = index_q;
  assign o_valid = (state_q == GRANTED);

endmodule
